// File: rtl/fifo_serializer.sv
// Drains a show-ahead FIFO one word at a time and transmits each word LSB-first
// as a bit stream over valid/ready, with a last-bit marker and a wrapping word count.
module fifo_serializer #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] pop_data_i,
    output logic              pop_o,
    input  logic              ser_ready_i,
    output logic              ser_valid_o,
    output logic              ser_data_o,
    output logic              ser_last_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  words_o
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              is_last;

    assign is_last = (bit_cnt_q == LAST_IDX);
    assign words_o = words_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            words_q   <= words_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        words_d     = words_q;
        pop_o       = 1'b0;
        ser_valid_o = 1'b0;
        ser_data_o  = 1'b0;
        ser_last_o  = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                // The reset term keeps pop low while reset is still asserted.
                if (!empty_i && !reset) begin
                    pop_o     = 1'b1;
                    shift_d   = pop_data_i;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid_o = 1'b1;
                ser_data_o  = shift_q[0];
                ser_last_o  = is_last;
                busy_o      = 1'b1;
                if (ser_ready_i) begin
                    if (!is_last) begin
                        shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end else begin
                        words_d = words_q + CNT_W'(1);
                        // Reload on the last-bit handshake so consecutive words leave no gap.
                        if (!empty_i) begin
                            pop_o     = 1'b1;
                            shift_d   = pop_data_i;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: an in-bench FIFO plus a word/bit-index model checked every
// cycle, directed scenarios with literal expectations, then a randomized soak.
module tb_fifo_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       empty_i = 1'b1;
    logic [3:0] pop_data_i = 4'h0;
    logic       ser_ready_i = 1'b0;
    logic       pop_o, ser_valid_o, ser_data_o, ser_last_o, busy_o;
    logic [7:0] words_o;
    logic       n_pop, n_valid, n_data, n_last, n_busy;
    logic [1:0] n_words;

    always #5 clk = ~clk;

    fifo_serializer #(.DATA_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .empty_i(empty_i), .pop_data_i(pop_data_i),
        .pop_o(pop_o), .ser_ready_i(ser_ready_i), .ser_valid_o(ser_valid_o),
        .ser_data_o(ser_data_o), .ser_last_o(ser_last_o), .busy_o(busy_o),
        .words_o(words_o)
    );

    fifo_serializer #(.DATA_W(4), .CNT_W(2)) dut_n (
        .clk(clk), .reset(reset), .empty_i(empty_i), .pop_data_i(pop_data_i),
        .pop_o(n_pop), .ser_ready_i(ser_ready_i), .ser_valid_o(n_valid),
        .ser_data_o(n_data), .ser_last_o(n_last), .busy_o(n_busy),
        .words_o(n_words)
    );

    int vectors = 0;
    int miscompares = 0;

    // Bench-side FIFO and behavioural model: which word is held and which bit is on the wire.
    logic [3:0] fq[$];
    bit         m_busy = 0;
    logic [3:0] m_word = 4'h0;
    int         m_idx = 0;
    int         m_cnt = 0;

    // Observation accumulators for directed checks.
    logic [31:0] acc;
    int          nbits, pops, stalls, gaps;
    bit          seen_valid;
    logic [1:0]  seq[$];
    logic [1:0]  prev_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_obs();
        acc = '0; nbits = 0; pops = 0; stalls = 0; gaps = 0; seen_valid = 0;
    endtask

    task automatic step(input bit r, input bit rdy);
        bit e_pop, e_valid, e_data, e_last, e_busy;
        bit emp;
        logic [3:0] head;
        @(negedge clk);
        emp  = (fq.size() == 0);
        head = emp ? 4'h0 : fq[0];
        reset = r; ser_ready_i = rdy; empty_i = emp; pop_data_i = head;
        if (r) begin m_busy = 0; m_idx = 0; m_cnt = 0; end
        e_pop = 0; e_valid = 0; e_data = 0; e_last = 0; e_busy = 0;
        if (!r) begin
            if (!m_busy) e_pop = !emp;
            else begin
                e_valid = 1; e_busy = 1;
                e_data  = m_word[m_idx];
                e_last  = (m_idx == 3);
                e_pop   = rdy && (m_idx == 3) && !emp;
            end
        end
        #1;
        chk("pop",   {31'd0, pop_o},       {31'd0, e_pop});
        chk("valid", {31'd0, ser_valid_o}, {31'd0, e_valid});
        chk("data",  {31'd0, ser_data_o},  {31'd0, e_data});
        chk("last",  {31'd0, ser_last_o},  {31'd0, e_last});
        chk("busy",  {31'd0, busy_o},      {31'd0, e_busy});
        chk("words", {24'd0, words_o},     32'(m_cnt % 256));
        chk("words_n", {30'd0, n_words},   32'(m_cnt % 4));
        chk("pop_n", {31'd0, n_pop},       {31'd0, e_pop});
        if (ser_valid_o && rdy && nbits < 32) begin acc[nbits] = ser_data_o; nbits++; end
        if (pop_o) pops++;
        if (ser_valid_o && !rdy) stalls++;
        if (ser_valid_o) seen_valid = 1;
        else if (seen_valid && busy_o == 0 && fq.size() != 0) gaps++;
        if (n_words !== prev_n) begin seq.push_back(n_words); prev_n = n_words; end
        @(posedge clk);
        if (!r) begin
            if (!m_busy) begin
                if (!emp) begin m_word = fq.pop_front(); m_idx = 0; m_busy = 1; end
            end else if (rdy) begin
                if (m_idx < 3) m_idx++;
                else begin
                    m_cnt++;
                    if (!emp) begin m_word = fq.pop_front(); m_idx = 0; end
                    else m_busy = 0;
                end
            end
        end
    endtask

    task automatic drain(input bit rdy);
        int n = 0;
        while ((m_busy || fq.size() != 0) && n < 300) begin
            step(0, rdy); n++;
        end
        if (m_busy || fq.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: busy=%0d fifo=%0d required idle", m_busy, fq.size());
        end
        step(0, rdy);
    endtask

    initial begin
        prev_n = 2'd0;
        clear_obs();

        // Reset held 3 cycles with a word waiting: nothing may pop.
        fq.push_back(4'h3);
        for (int i = 0; i < 3; i++) step(1, 1);
        chk("rst_pops", 32'(pops), 32'd0);
        chk("rst_words", {24'd0, words_o}, 32'd0);
        fq.delete();
        step(0, 1);

        // Single word 0xD.
        clear_obs();
        fq.push_back(4'hD);
        drain(1);
        chk("single_bits", acc, 32'hD);
        chk("single_nbits", 32'(nbits), 32'd4);
        chk("single_pops", 32'(pops), 32'd1);
        chk("single_words", {24'd0, words_o}, 32'd1);

        // Back-to-back, four words.
        clear_obs();
        fq.push_back(4'hD); fq.push_back(4'hE); fq.push_back(4'hA); fq.push_back(4'hD);
        drain(1);
        chk("b2b_bits", acc, 32'hDAED);
        chk("b2b_nbits", 32'(nbits), 32'd16);
        chk("b2b_pops", 32'(pops), 32'd4);
        chk("b2b_gaps", 32'(gaps), 32'd0);
        chk("b2b_words", {24'd0, words_o}, 32'd5);

        // Backpressure: hold bit 1 of 0xE for 3 extra cycles.
        clear_obs();
        fq.push_back(4'hE);
        step(0, 1);
        step(0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            chk("bp_hold_data", {31'd0, ser_data_o}, 32'd1);
        end
        drain(1);
        chk("bp_bits", acc, 32'hE);
        chk("bp_stalls", 32'(stalls), 32'd3);
        chk("bp_pops", 32'(pops), 32'd1);

        // Reset mid-word: 0xA is abandoned after two bits, 0x5 follows.
        clear_obs();
        fq.push_back(4'hA); fq.push_back(4'h5);
        step(0, 1); step(0, 1); step(0, 1);
        chk("mid_partial", acc, 32'h2);
        step(1, 1);
        chk("mid_rst_valid", {31'd0, ser_valid_o}, 32'd0);
        step(1, 1);
        clear_obs();
        drain(1);
        chk("mid_bits", acc, 32'h5);
        chk("mid_nbits", 32'(nbits), 32'd4);
        chk("mid_pops", 32'(pops), 32'd1);
        chk("mid_words", {24'd0, words_o}, 32'd1);

        // Counter wrap on the 2-bit instance.
        step(1, 1);
        step(0, 1);
        seq.delete(); prev_n = n_words;
        for (int i = 0; i < 5; i++) fq.push_back(4'(i + 3));
        drain(1);
        chk("wrap_len", 32'(seq.size()), 32'd5);
        if (seq.size() == 5) begin
            chk("wrap_s0", {30'd0, seq[0]}, 32'd1);
            chk("wrap_s1", {30'd0, seq[1]}, 32'd2);
            chk("wrap_s2", {30'd0, seq[2]}, 32'd3);
            chk("wrap_s3", {30'd0, seq[3]}, 32'd0);
            chk("wrap_s4", {30'd0, seq[4]}, 32'd1);
        end

        // Randomized soak.
        for (int c = 0; c < 1500; c++) begin
            if (fq.size() < 4 && $urandom_range(0, 2) == 0) fq.push_back(4'($urandom_range(0, 15)));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));
        end
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
